// File: rtl/alu_sequencer_if.sv
// Bundles the control-unit request channel, the ALU launch/completion channel
// and the captured-result outputs of the ALU sequencer.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_start;
  logic [63:0] alu_out;
  logic        alu_finished;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic        hi_write;
  logic        z_valid;
  logic        err;
  logic        busy;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_out, alu_finished,
    output req_ready, alu_opcode, alu_a, alu_b, alu_start,
           z_lo, z_hi, hi_write, z_valid, err, busy
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_out, alu_finished,
    input  req_ready, alu_opcode, alu_a, alu_b, alu_start,
           z_lo, z_hi, hi_write, z_valid, err, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: latch request, strobe start, mask one
// stale completion cycle, wait (with timeout) for the result, then pulse z_valid.
module alu_sequencer #(
  parameter int unsigned START_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           clock,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LAUNCH, BLANK, WAIT, DONE} state_t;

  localparam logic [4:0] OP_FIRST    = 5'b00011;
  localparam logic [4:0] OP_LAST     = 5'b10010;
  localparam logic [4:0] OP_MUL      = 5'b01111;
  localparam logic [4:0] OP_DIV      = 5'b10000;
  localparam logic [3:0] START_LIM   = 4'(START_CYCLES);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  start_cnt_q, start_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]  alu_opcode_q, alu_opcode_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        alu_start_q, alu_start_d;
  logic [31:0] z_lo_q, z_lo_d;
  logic [31:0] z_hi_q, z_hi_d;
  logic        hi_write_q, hi_write_d;
  logic        z_valid_q, z_valid_d;
  logic        err_q, err_d;

  function automatic logic op_legal(input logic [4:0] op);
    return (op >= OP_FIRST) && (op <= OP_LAST);
  endfunction

  function automatic logic op_writes_hi(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_start_d  = 1'b0;
    z_lo_d       = z_lo_q;
    z_hi_d       = z_hi_q;
    hi_write_d   = 1'b0;
    z_valid_d    = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          alu_opcode_d = bus.req_opcode;
          alu_a_d      = bus.req_a;
          alu_b_d      = bus.req_b;
          if (op_legal(bus.req_opcode)) begin
            err_d       = 1'b0;
            alu_start_d = 1'b1;
            start_cnt_d = 4'd1;
            state_d     = LAUNCH;
          end else begin
            // Illegal opcodes skip the ALU entirely and report straight away.
            err_d     = 1'b1;
            z_valid_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      LAUNCH: begin
        if (start_cnt_q == START_LIM) begin
          start_cnt_d = 4'd0;
          state_d     = BLANK;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
          alu_start_d = 1'b1;
        end
      end
      BLANK: begin
        wait_cnt_d = 8'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Completion is checked first so a finish on the timeout edge still captures.
        if (bus.alu_finished) begin
          z_lo_d     = bus.alu_out[31:0];
          z_hi_d     = bus.alu_out[63:32];
          hi_write_d = op_writes_hi(alu_opcode_q);
          z_valid_d  = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = DONE;
        end else if (wait_cnt_q + 8'd1 == TIMEOUT_LIM) begin
          err_d      = 1'b1;
          z_valid_d  = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      start_cnt_q  <= 4'd0;
      wait_cnt_q   <= 8'd0;
      alu_opcode_q <= 5'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_start_q  <= 1'b0;
      z_lo_q       <= 32'd0;
      z_hi_q       <= 32'd0;
      hi_write_q   <= 1'b0;
      z_valid_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_start_q  <= alu_start_d;
      z_lo_q       <= z_lo_d;
      z_hi_q       <= z_hi_d;
      hi_write_q   <= hi_write_d;
      z_valid_q    <= z_valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.z_lo       = z_lo_q;
  assign bus.z_hi       = z_hi_q;
  assign bus.hi_write   = hi_write_q;
  assign bus.z_valid    = z_valid_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer: plays both control unit and ALU and
// predicts each transaction's timeline and results from the sequencing rules.
module tb_alu_sequencer;

  localparam int ST = 1;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] exp_z_lo = '0;
  logic [31:0] exp_z_hi = '0;
  logic        exp_err  = 1'b0;

  alu_sequencer_if bus();

  alu_sequencer #(.START_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    case (op)
      5'b00011: return {32'd0, a + b};
      5'b01111: return wa * wb;
      default:  return {a ^ b, a - b};
    endcase
  endfunction

  // mode: -1 = finished held high throughout, 0 = never finishes,
  // d > 0 = one-cycle finished pulse sampled d edges after alu_start falls.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int mode, input bit poke);
    logic        legal, cap, wide, e_err;
    logic [63:0] res;
    int          k, done;
    int          st_cnt = 0, st_bad = 0, zv_cnt = 0, zv_at = -1, hw_extra = 0;
    logic [31:0] zlo_at = 'x, zhi_at = 'x, a_at = 'x, b_at = 'x;
    logic [4:0]  op_at = 'x;
    logic        hw_at = 'x, err_at = 'x, err_acc = 'x, rdy_after = 'x;
    bit          fin;

    legal = (op >= 5'd3) && (op <= 5'd18);
    wide  = (op == 5'd15) || (op == 5'd16);
    res   = alu_model(op, a, b);
    if (!legal) begin
      cap = 1'b0; e_err = 1'b1; done = 0;
    end else begin
      if (mode == -1) k = 1;
      else if (mode >= 2 && mode - 1 <= TO) k = mode - 1;
      else k = 0;
      cap   = (k != 0);
      e_err = !cap;
      done  = cap ? ST + 1 + k : ST + 1 + TO;
    end

    @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_opcode   = op;
    bus.req_a        = a;
    bus.req_b        = b;
    bus.alu_finished = (mode == -1);
    bus.alu_out      = (mode == -1) ? res : ~res;

    for (int j = 0; j <= done + 1; j++) begin
      @(negedge clock);
      if (j == 0) begin
        err_acc        = bus.err;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 5'($urandom);
        bus.req_a      = $urandom;
        bus.req_b      = $urandom;
      end
      if (bus.alu_start) begin
        st_cnt++;
        if (!legal || j >= ST) st_bad++;
      end
      if (bus.z_valid) begin
        zv_cnt++;
        zv_at  = j;
        zlo_at = bus.z_lo;
        zhi_at = bus.z_hi;
        hw_at  = bus.hi_write;
        err_at = bus.err;
        op_at  = bus.alu_opcode;
        a_at   = bus.alu_a;
        b_at   = bus.alu_b;
      end else if (bus.hi_write) begin
        hw_extra++;
      end
      if (j == done + 1) rdy_after = bus.req_ready;
      fin = (mode == -1) || (mode > 0 && j + 1 == ST + mode);
      bus.alu_finished = fin;
      bus.alu_out      = fin ? res : ~res;
      if (poke && done >= 3 && j == 1) begin
        bus.req_valid  = 1'b1;
        bus.req_opcode = 5'b00011;
        bus.req_a      = ~a;
        bus.req_b      = ~b;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.alu_finished = 1'b0;
    bus.req_valid    = 1'b0;

    if (cap) begin
      exp_z_lo = res[31:0];
      exp_z_hi = res[63:32];
    end
    exp_err = e_err;

    n_chk++; if (zv_cnt !== 1) $display("FAIL %s zv_count got %0d want 1", name, zv_cnt); else n_pass++;
    n_chk++; if (zv_at !== done) $display("FAIL %s zv_cycle got %0d want %0d", name, zv_at, done); else n_pass++;
    n_chk++; if (st_cnt !== (legal ? ST : 0)) $display("FAIL %s start_cycles got %0d want %0d", name, st_cnt, legal ? ST : 0); else n_pass++;
    n_chk++; if (st_bad !== 0) $display("FAIL %s start_misplaced got %0d want 0", name, st_bad); else n_pass++;
    n_chk++; if (zlo_at !== exp_z_lo) $display("FAIL %s z_lo got %h want %h", name, zlo_at, exp_z_lo); else n_pass++;
    n_chk++; if (zhi_at !== exp_z_hi) $display("FAIL %s z_hi got %h want %h", name, zhi_at, exp_z_hi); else n_pass++;
    n_chk++; if (hw_at !== (cap && wide)) $display("FAIL %s hi_write got %b want %b", name, hw_at, cap && wide); else n_pass++;
    n_chk++; if (hw_extra !== 0) $display("FAIL %s hi_write_outside_done got %0d want 0", name, hw_extra); else n_pass++;
    n_chk++; if (err_at !== e_err) $display("FAIL %s err got %b want %b", name, err_at, e_err); else n_pass++;
    n_chk++; if (err_acc !== !legal) $display("FAIL %s err_after_accept got %b want %b", name, err_acc, !legal); else n_pass++;
    n_chk++; if ({op_at, a_at, b_at} !== {op, a, b})
      $display("FAIL %s operands got %h/%h/%h want %h/%h/%h", name, op_at, a_at, b_at, op, a, b); else n_pass++;
    n_chk++; if (rdy_after !== 1'b1) $display("FAIL %s req_ready_after got %b want 1", name, rdy_after); else n_pass++;
  endtask

  task automatic test_idle(input string name, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.z_valid !== 1'b0 || bus.alu_start !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.busy !== 1'b0 || bus.hi_write !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL %s idle_activity got %0d want 0", name, bad); else n_pass++;
    n_chk++; if (bus.err !== exp_err) $display("FAIL %s err_sticky got %b want %b", name, bus.err, exp_err); else n_pass++;
    n_chk++; if ({bus.z_hi, bus.z_lo} !== {exp_z_hi, exp_z_lo})
      $display("FAIL %s z_hold got %h want %h", name, {bus.z_hi, bus.z_lo}, {exp_z_hi, exp_z_lo}); else n_pass++;
  endtask

  task automatic test_reset;
    bus.req_valid    = 1'b1;
    bus.req_opcode   = 5'b00011;
    bus.req_a        = 32'hdead_beef;
    bus.req_b        = 32'h1234_5678;
    bus.alu_finished = 1'b0;
    bus.alu_out      = '0;
    reset            = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_chk++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL reset ready_busy got %b%b want 10", bus.req_ready, bus.busy); else n_pass++;
    n_chk++; if ({bus.alu_start, bus.z_valid, bus.hi_write, bus.err} !== 4'b0)
      $display("FAIL reset strobes got %b want 0000", {bus.alu_start, bus.z_valid, bus.hi_write, bus.err}); else n_pass++;
    n_chk++; if ({bus.z_hi, bus.z_lo} !== 64'd0) $display("FAIL reset z got %h want 0", {bus.z_hi, bus.z_lo}); else n_pass++;
    n_chk++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== 69'd0)
      $display("FAIL reset operands got %h want 0", {bus.alu_opcode, bus.alu_a, bus.alu_b}); else n_pass++;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    exp_z_lo = '0; exp_z_hi = '0; exp_err = 1'b0;
    test_idle("reset_idle", 3);
  endtask

  task automatic test_reset_in_launch;
    int bad = 0;
    run_op("pre_reset", 5'b00011, 32'h0000_1111, 32'h0000_2222, 2, 1'b0);
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_opcode = 5'b01111;
    bus.req_a      = 32'h55;
    bus.req_b      = 32'h66;
    @(negedge clock);
    n_chk++; if (bus.alu_start !== 1'b1) $display("FAIL reset_launch start_before got %b want 1", bus.alu_start); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_chk++; if ({bus.alu_start, bus.z_valid, bus.req_ready} !== 3'b001)
      $display("FAIL reset_launch after_edge got %b want 001", {bus.alu_start, bus.z_valid, bus.req_ready}); else n_pass++;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    exp_z_lo = '0; exp_z_hi = '0; exp_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.alu_finished = (i == 2);
      bus.alu_out      = 64'hffff_ffff_ffff_ffff;
      @(negedge clock);
      if (bus.z_valid !== 1'b0 || bus.alu_start !== 1'b0) bad++;
    end
    bus.alu_finished = 1'b0;
    n_chk++; if (bad !== 0) $display("FAIL reset_launch aborted_activity got %0d want 0", bad); else n_pass++;
    test_idle("reset_launch_idle", 2);
  endtask

  task automatic test_add;          run_op("add", 5'b00011, 32'd5, 32'd7, 2, 1'b0); endtask
  task automatic test_mul;          run_op("mul", 5'b01111, 32'h10000, 32'h10000, 32, 1'b0); endtask
  task automatic test_stale;        run_op("stale", 5'($urandom_range(3, 18)), $urandom, $urandom, -1, 1'b0); endtask
  task automatic test_blank_mask;   run_op("blank_mask", 5'b00100, $urandom, $urandom, 1, 1'b0); endtask

  task automatic test_timeout;
    run_op("timeout", 5'b10000, $urandom, $urandom, 0, 1'b0);
    test_idle("timeout_idle", 4);
    run_op("err_clear", 5'b00011, $urandom, $urandom, 3, 1'b0);
    run_op("timeout_edge_capture", 5'b10000, $urandom, $urandom, TO + 1, 1'b0);
  endtask

  task automatic test_illegal;
    run_op("illegal_1f", 5'b11111, $urandom, $urandom, 2, 1'b0);
    test_idle("illegal_idle", 2);
    run_op("illegal_02", 5'b00010, $urandom, $urandom, 2, 1'b0);
    run_op("illegal_13", 5'b10011, $urandom, $urandom, 2, 1'b0);
    run_op("legal_12", 5'b10010, $urandom, $urandom, 4, 1'b0);
  endtask

  task automatic test_busy_ignore;
    run_op("busy_poke", 5'b00101, $urandom, $urandom, 5, 1'b1);
    test_idle("busy_poke_idle", 4);
  endtask

  task automatic test_random;
    int mode;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 4))
        0:       mode = -1;
        1:       mode = 0;
        default: mode = int'($urandom_range(1, TO + 2));
      endcase
      run_op("random", 5'($urandom), $urandom, $urandom, mode, 1'($urandom));
    end
    test_idle("random_idle", 2);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_stale();
    test_blank_mask();
    test_timeout();
    test_illegal();
    test_busy_ignore();
    test_reset_in_launch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
